scarv_cop_palu_issue: RTL and testbench

Issue/writeback stage directly upstream and downstream of the coprocessor packed ALU (`palu`). It accepts one decoded instruction with its already-read register operands and holds them stable on the `palu` input bus. It drives `palu_ivalid` until `palu_idone`, including multi-cycle multiplies. It then registers the `palu` result and writes it into the CPR file through the byte-enabled write port, with a flush input and a watchdog timeout.

---
 rtl/scarv_cop_palu_issue.sv | 145 ++++++++++++++
 tb/tb_scarv_cop_palu_issue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_palu_issue.sv
// rtl/scarv_cop_palu_issue.sv - issue/writeback stage around the coprocessor packed ALU
module scarv_cop_palu_issue #(
   parameter int TIMEOUT = 64,
   parameter int RW      = 4
) (
   input  logic          g_clk,
   input  logic          g_reset,
   input  logic          flush,
   input  logic          id_valid,
   output logic          id_ready,
   input  logic [3:0]    id_class,
   input  logic [4:0]    id_subclass,
   input  logic [2:0]    id_pw,
   input  logic [31:0]   id_imm,
   input  logic [RW-1:0] id_rd,
   input  logic [31:0]   id_gpr_rs1,
   input  logic [31:0]   id_crs1,
   input  logic [31:0]   id_crs2,
   input  logic [31:0]   id_crs3,
   output logic          palu_ivalid,
   input  logic          palu_idone,
   output logic [31:0]   gpr_rs1,
   output logic [31:0]   palu_rs1,
   output logic [31:0]   palu_rs2,
   output logic [31:0]   palu_rs3,
   output logic [31:0]   palu_imm,
   output logic [2:0]    palu_pw,
   output logic [3:0]    palu_class,
   output logic [4:0]    palu_subclass,
   input  logic [3:0]    palu_cpr_rd_ben,
   input  logic [31:0]   palu_cpr_rd_wdata,
   output logic          cpr_wen,
   output logic [RW-1:0] cpr_waddr,
   output logic [3:0]    cpr_wben,
   output logic [31:0]   cpr_wdata,
   output logic          insn_done,
   output logic          insn_timeout,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t        r_state;
   logic [7:0]    r_cnt;
   logic [RW-1:0] r_rd;
   logic [31:0]   r_gpr_rs1, r_rs1, r_rs2, r_rs3, r_imm;
   logic [2:0]    r_pw;
   logic [3:0]    r_class;
   logic [4:0]    r_subclass;
   logic [RW-1:0] r_waddr;
   logic [3:0]    r_wben;
   logic [31:0]   r_wdata;

   logic w_accept;
   logic w_tmo;
   logic w_wb_live;

   assign id_ready  = !g_reset && !flush && (r_state == S_IDLE || r_state == S_WB);
   assign w_accept  = id_valid && id_ready;
   assign w_tmo     = (r_state == S_EXEC) && (r_cnt == 8'(TIMEOUT - 1));
   assign w_wb_live = !g_reset && !flush && (r_state == S_WB);

   assign palu_ivalid   = (r_state == S_EXEC);
   assign busy          = (r_state != S_IDLE);
   assign insn_done     = w_wb_live;
   assign cpr_wen       = w_wb_live && (r_wben != 4'h0);
   assign insn_timeout  = !g_reset && !flush && w_tmo;

   assign gpr_rs1       = r_gpr_rs1;
   assign palu_rs1      = r_rs1;
   assign palu_rs2      = r_rs2;
   assign palu_rs3      = r_rs3;
   assign palu_imm      = r_imm;
   assign palu_pw       = r_pw;
   assign palu_class    = r_class;
   assign palu_subclass = r_subclass;
   assign cpr_waddr     = r_waddr;
   assign cpr_wben      = r_wben;
   assign cpr_wdata     = r_wdata;

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_rd       <= '0;
         r_gpr_rs1  <= 32'd0;
         r_rs1      <= 32'd0;
         r_rs2      <= 32'd0;
         r_rs3      <= 32'd0;
         r_imm      <= 32'd0;
         r_pw       <= 3'd0;
         r_class    <= 4'd0;
         r_subclass <= 5'd0;
         r_waddr    <= '0;
         r_wben     <= 4'h0;
         r_wdata    <= 32'd0;
      end else begin
         // Operands only move on accept so palu sees a stable bus for the whole op.
         if (w_accept) begin
            r_rd       <= id_rd;
            r_gpr_rs1  <= id_gpr_rs1;
            r_rs1      <= id_crs1;
            r_rs2      <= id_crs2;
            r_rs3      <= id_crs3;
            r_imm      <= id_imm;
            r_pw       <= id_pw;
            r_class    <= id_class;
            r_subclass <= id_subclass;
         end
         if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_state <= S_EXEC;
                     r_cnt   <= 8'd0;
                  end
               end
               S_EXEC: begin
                  // Watchdog outranks a late completion in the same cycle.
                  if (w_tmo) begin
                     r_state <= S_IDLE;
                     r_cnt   <= 8'd0;
                  end else if (palu_idone) begin
                     r_state <= S_WB;
                     r_waddr <= r_rd;
                     r_wben  <= palu_cpr_rd_ben;
                     r_wdata <= palu_cpr_rd_wdata;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_WB: begin
                  r_state <= w_accept ? S_EXEC : S_IDLE;
                  r_cnt   <= 8'd0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scarv_cop_palu_issue.sv
// tb/tb_scarv_cop_palu_issue.sv - directed bench for the palu issue/writeback stage
module tb_scarv_cop_palu_issue;

   logic        g_clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        flush = 1'b0;
   logic        id_valid = 1'b0;
   logic [3:0]  id_class = 4'd0;
   logic [4:0]  id_subclass = 5'd0;
   logic [2:0]  id_pw = 3'd0;
   logic [31:0] id_imm = 32'd0;
   logic [3:0]  id_rd = 4'd0;
   logic [31:0] id_gpr_rs1 = 32'd0;
   logic [31:0] id_crs1 = 32'd0;
   logic [31:0] id_crs2 = 32'd0;
   logic [31:0] id_crs3 = 32'd0;
   logic        palu_idone = 1'b0;
   logic [3:0]  palu_cpr_rd_ben = 4'h0;
   logic [31:0] palu_cpr_rd_wdata = 32'd0;

   logic        id_ready, palu_ivalid, cpr_wen, insn_done, insn_timeout, busy;
   logic [31:0] gpr_rs1, palu_rs1, palu_rs2, palu_rs3, palu_imm, cpr_wdata;
   logic [2:0]  palu_pw;
   logic [3:0]  palu_class, cpr_waddr, cpr_wben;
   logic [4:0]  palu_subclass;

   logic        wd_id_ready, wd_palu_ivalid, wd_cpr_wen, wd_insn_done, wd_insn_timeout, wd_busy;
   logic [31:0] wd_gpr_rs1, wd_palu_rs1, wd_palu_rs2, wd_palu_rs3, wd_palu_imm, wd_cpr_wdata;
   logic [2:0]  wd_palu_pw;
   logic [3:0]  wd_palu_class, wd_cpr_waddr, wd_cpr_wben;
   logic [4:0]  wd_palu_subclass;

   int total = 0;
   int bad = 0;

   always #5 g_clk = ~g_clk;

   scarv_cop_palu_issue u_dut (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
      .id_class(id_class), .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm), .id_rd(id_rd),
      .id_gpr_rs1(id_gpr_rs1), .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
      .palu_ivalid(palu_ivalid), .palu_idone(palu_idone), .gpr_rs1(gpr_rs1),
      .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3), .palu_imm(palu_imm),
      .palu_pw(palu_pw), .palu_class(palu_class), .palu_subclass(palu_subclass),
      .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
      .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr), .cpr_wben(cpr_wben), .cpr_wdata(cpr_wdata),
      .insn_done(insn_done), .insn_timeout(insn_timeout), .busy(busy)
   );

   scarv_cop_palu_issue #(.TIMEOUT(8)) u_wd (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .id_valid(id_valid), .id_ready(wd_id_ready),
      .id_class(id_class), .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm), .id_rd(id_rd),
      .id_gpr_rs1(id_gpr_rs1), .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
      .palu_ivalid(wd_palu_ivalid), .palu_idone(palu_idone), .gpr_rs1(wd_gpr_rs1),
      .palu_rs1(wd_palu_rs1), .palu_rs2(wd_palu_rs2), .palu_rs3(wd_palu_rs3), .palu_imm(wd_palu_imm),
      .palu_pw(wd_palu_pw), .palu_class(wd_palu_class), .palu_subclass(wd_palu_subclass),
      .palu_cpr_rd_ben(palu_cpr_rd_ben), .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
      .cpr_wen(wd_cpr_wen), .cpr_waddr(wd_cpr_waddr), .cpr_wben(wd_cpr_wben), .cpr_wdata(wd_cpr_wdata),
      .insn_done(wd_insn_done), .insn_timeout(wd_insn_timeout), .busy(wd_busy)
   );

   // Inputs change just after the falling edge; outputs are checked 1ns later.
   task automatic next_cycle();
      @(negedge g_clk);
   endtask

   task automatic offer(input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b);
      id_valid   = 1'b1;
      id_rd      = rd;
      id_crs1    = a;
      id_crs2    = b;
      id_crs3    = a ^ b;
      id_gpr_rs1 = a + b;
      id_imm     = 32'h0000_0100 | {28'd0, rd};
      id_class   = 4'h2;
      id_subclass= 5'h01;
      id_pw      = 3'd1;
   endtask

   task automatic test_reset();
      g_reset = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL reset_id_ready got=%b exp=0", id_ready); end
      total++; if ({palu_ivalid, cpr_wen, insn_done, insn_timeout, busy} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {palu_ivalid, cpr_wen, insn_done, insn_timeout, busy}); end
      total++; if ({palu_rs1, cpr_wdata, cpr_wben, cpr_waddr} !== 72'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {palu_rs1, cpr_wdata, cpr_wben, cpr_waddr}); end
      next_cycle();
      g_reset = 1'b0;
      #1;
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL post_reset_id_ready got=%b exp=1", id_ready); end
   endtask

   task automatic test_padd();
      next_cycle();
      offer(4'd5, 32'h0001_0002, 32'h0003_0004);
      next_cycle();
      id_valid = 1'b0;
      palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h0004_0006;
      #1;
      total++; if (palu_ivalid !== 1'b1 || cpr_wen !== 1'b0) begin bad++; $display("FAIL padd_exec ivalid=%b wen=%b exp=1/0", palu_ivalid, cpr_wen); end
      total++; if (palu_rs1 !== 32'h0001_0002 || palu_rs2 !== 32'h0003_0004 || palu_rs3 !== 32'h0002_0006) begin bad++; $display("FAIL padd_operands got=%h %h %h", palu_rs1, palu_rs2, palu_rs3); end
      total++; if (gpr_rs1 !== 32'h0004_0006 || palu_imm !== 32'h0000_0105 || palu_class !== 4'h2 || palu_subclass !== 5'h01 || palu_pw !== 3'd1) begin bad++; $display("FAIL padd_fields got=%h %h %h %h %h", gpr_rs1, palu_imm, palu_class, palu_subclass, palu_pw); end
      next_cycle();
      palu_idone = 1'b0; palu_cpr_rd_wdata = 32'hDEAD_BEEF;
      #1;
      total++; if ({cpr_wen, insn_done, cpr_waddr, cpr_wben, cpr_wdata} !== {1'b1, 1'b1, 4'd5, 4'hF, 32'h0004_0006}) begin bad++; $display("FAIL padd_write got=%b%b %h %h %h exp=11 5 f 00040006", cpr_wen, insn_done, cpr_waddr, cpr_wben, cpr_wdata); end
      total++; if (palu_ivalid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL padd_wb_state ivalid=%b busy=%b exp=0/1", palu_ivalid, busy); end
      next_cycle();
      #1;
      total++; if ({cpr_wen, insn_done, busy} !== 3'b000) begin bad++; $display("FAIL padd_single_pulse got=%b exp=000", {cpr_wen, insn_done, busy}); end
   endtask

   task automatic test_multiply();
      int hi = 0;
      int unstable = 0;
      next_cycle();
      offer(4'd3, 32'hA5A5_5A5A, 32'h1234_5678);
      for (int k = 1; k <= 9; k++) begin
         next_cycle();
         id_valid = 1'b0;
         id_crs1 = 32'h0;
         palu_idone = (k == 9);
         palu_cpr_rd_ben = 4'h3; palu_cpr_rd_wdata = 32'h0000_BEEF;
         #1;
         if (palu_ivalid === 1'b1) hi++;
         if (palu_rs1 !== 32'hA5A5_5A5A || palu_rs2 !== 32'h1234_5678 || cpr_wen !== 1'b0) unstable++;
      end
      next_cycle();
      palu_idone = 1'b0;
      #1;
      total++; if (hi !== 9) begin bad++; $display("FAIL mul_ivalid_cycles got=%0d exp=9", hi); end
      total++; if (unstable !== 0) begin bad++; $display("FAIL mul_stability got=%0d exp=0", unstable); end
      total++; if ({cpr_wen, insn_done, cpr_waddr, cpr_wben, cpr_wdata} !== {1'b1, 1'b1, 4'd3, 4'h3, 32'h0000_BEEF}) begin bad++; $display("FAIL mul_write got=%b%b %h %h %h exp=11 3 3 0000beef", cpr_wen, insn_done, cpr_waddr, cpr_wben, cpr_wdata); end
      total++; if (insn_timeout !== 1'b0) begin bad++; $display("FAIL mul_no_timeout got=%b exp=0", insn_timeout); end
      next_cycle();
   endtask

   task automatic test_cmov_false();
      offer(4'd9, 32'h1, 32'h2);
      next_cycle();
      id_valid = 1'b0;
      palu_idone = 1'b1; palu_cpr_rd_ben = 4'h0; palu_cpr_rd_wdata = 32'h5555_5555;
      next_cycle();
      palu_idone = 1'b0;
      #1;
      total++; if ({insn_done, cpr_wen, cpr_wben} !== {1'b1, 1'b0, 4'h0}) begin bad++; $display("FAIL cmov_false got=%b%b %h exp=10 0", insn_done, cpr_wen, cpr_wben); end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      offer(4'd1, 32'h11, 32'h0);
      next_cycle();
      offer(4'd2, 32'h22, 32'h0);
      palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h0000_0011;
      #1;
      total++; if (id_ready !== 1'b0 || palu_rs1 !== 32'h11) begin bad++; $display("FAIL b2b_exec1 ready=%b rs1=%h exp=0/11", id_ready, palu_rs1); end
      next_cycle();
      palu_idone = 1'b0;
      #1;
      total++; if ({cpr_wen, cpr_waddr, cpr_wdata, id_ready, palu_ivalid} !== {1'b1, 4'd1, 32'h11, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_wb1 wen=%b addr=%h data=%h ready=%b ivalid=%b", cpr_wen, cpr_waddr, cpr_wdata, id_ready, palu_ivalid); end
      next_cycle();
      id_valid = 1'b0;
      palu_idone = 1'b1; palu_cpr_rd_wdata = 32'h0000_0022;
      #1;
      total++; if ({palu_ivalid, cpr_wen, palu_rs1} !== {1'b1, 1'b0, 32'h22}) begin bad++; $display("FAIL b2b_exec2 ivalid=%b wen=%b rs1=%h exp=1 0 22", palu_ivalid, cpr_wen, palu_rs1); end
      next_cycle();
      palu_idone = 1'b0;
      #1;
      total++; if ({cpr_wen, cpr_waddr, cpr_wdata} !== {1'b1, 4'd2, 32'h22}) begin bad++; $display("FAIL b2b_wb2 wen=%b addr=%h data=%h exp=1 2 22", cpr_wen, cpr_waddr, cpr_wdata); end
      next_cycle();
   endtask

   task automatic test_watchdog();
      int tmo_ok = 0;
      int wd_writes = 0;
      offer(4'd4, 32'h4, 32'h4);
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         id_valid = 1'b0;
         palu_idone = 1'b0;
         #1;
         if (wd_insn_timeout === (k == 8)) tmo_ok++;
         if (wd_cpr_wen !== 1'b0 || wd_insn_done !== 1'b0) wd_writes++;
      end
      total++; if (tmo_ok !== 8) begin bad++; $display("FAIL wd_timeout_pulse got=%0d exp=8", tmo_ok); end
      total++; if (wd_writes !== 0) begin bad++; $display("FAIL wd_no_write got=%0d exp=0", wd_writes); end
      total++; if (insn_timeout !== 1'b0 || palu_ivalid !== 1'b1) begin bad++; $display("FAIL wd_default_still_exec tmo=%b ivalid=%b exp=0/1", insn_timeout, palu_ivalid); end
      next_cycle();
      #1;
      total++; if ({wd_id_ready, wd_busy, wd_insn_timeout, wd_cpr_wen} !== 4'b1000) begin bad++; $display("FAIL wd_after got=%b exp=1000", {wd_id_ready, wd_busy, wd_insn_timeout, wd_cpr_wen}); end
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
   endtask

   task automatic test_flush();
      next_cycle();
      offer(4'd7, 32'h77, 32'h77);
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         id_valid = 1'b0;
         flush = (k == 3);
      end
      #1;
      total++; if (id_ready !== 1'b0 || palu_ivalid !== 1'b1) begin bad++; $display("FAIL flush_exec ready=%b ivalid=%b exp=0/1", id_ready, palu_ivalid); end
      next_cycle();
      flush = 1'b0;
      palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF;
      #1;
      total++; if ({palu_ivalid, busy, cpr_wen, insn_done, id_ready} !== 5'b00001) begin bad++; $display("FAIL flush_exec_after got=%b exp=00001", {palu_ivalid, busy, cpr_wen, insn_done, id_ready}); end
      next_cycle();
      palu_idone = 1'b0;
      #1;
      total++; if ({cpr_wen, insn_done} !== 2'b00) begin bad++; $display("FAIL flush_exec_no_done got=%b exp=00", {cpr_wen, insn_done}); end
      offer(4'd8, 32'h88, 32'h0);
      next_cycle();
      id_valid = 1'b0;
      palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h0000_0088;
      next_cycle();
      palu_idone = 1'b0;
      flush = 1'b1;
      #1;
      total++; if ({cpr_wen, insn_done, id_ready} !== 3'b000) begin bad++; $display("FAIL flush_wb got=%b exp=000", {cpr_wen, insn_done, id_ready}); end
      next_cycle();
      flush = 1'b0;
      #1;
      total++; if ({busy, cpr_wen, insn_done} !== 3'b000) begin bad++; $display("FAIL flush_wb_after got=%b exp=000", {busy, cpr_wen, insn_done}); end
   endtask

   initial begin
      test_reset();
      test_padd();
      test_multiply();
      test_cmov_false();
      test_back_to_back();
      test_watchdog();
      test_flush();
      next_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
